// File: rtl/alu_pkg.sv
// alu_pkg: opcode encoding and request type shared by the ALU and its command issuer
package alu_pkg;
  typedef logic [4:0] op_t;
  typedef enum logic [4:0] {
    OP_ADD = 5'd0,
    OP_SUB,
    OP_SLL,
    OP_SRL,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_EQL,
    OP_LESSEQL,
    OP_GREQL = 5'd9
  } op_e;
  localparam op_e OP_LAST = OP_GREQL;
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    op_t         op;
  } alu_req_t;
endpackage

// File: rtl/alu.sv
// alu: combinational 32-bit ALU driven by the command issuer
// Ports: a_i/b_i operands, op_i opcode, alu_o result (0 for unknown opcodes).
// Comparisons are unsigned and return 1/0 in bit 0; shifts use b_i[4:0].
module alu
  import alu_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [4:0]  op_i,
  output logic [31:0] alu_o
);
  always_comb begin
    alu_o = '0;
    case (op_i)
      OP_ADD:     alu_o = a_i + b_i;
      OP_SUB:     alu_o = a_i - b_i;
      OP_SLL:     alu_o = a_i << b_i[4:0];
      OP_SRL:     alu_o = a_i >> b_i[4:0];
      OP_AND:     alu_o = a_i & b_i;
      OP_OR:      alu_o = a_i | b_i;
      OP_XOR:     alu_o = a_i ^ b_i;
      OP_EQL:     alu_o = {31'b0, a_i == b_i};
      OP_LESSEQL: alu_o = {31'b0, a_i <= b_i};
      OP_GREQL:   alu_o = {31'b0, a_i >= b_i};
      default:    alu_o = '0;
    endcase
  end
endmodule

// File: rtl/alu_req_fifo.sv
// alu_req_fifo: synchronous request FIFO with full/empty/occupancy
// Ports: clk_i, rst_ni (async active-low), push_i/data_i write side,
// pop_i/data_o read side (data_o shows the head), full_o, empty_o, count_o.
// Push while full and pop while empty are ignored, so callers may hold
// push_i = valid without gating it.
module alu_req_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  T                       data_i,
  input  logic                   pop_i,
  output T                       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  T               mem_q [DEPTH];
  logic [AW-1:0]  wr_q, rd_q;
  logic [AW:0]    cnt_q;
  logic           do_push, do_pop;
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  always_ff @(posedge clk_i)
    if (do_push) mem_q[wr_q] <= data_i;
  // Power-of-two depth: pointers wrap by natural overflow.
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + AW'(do_push);
      rd_q  <= rd_q + AW'(do_pop);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: queues ALU requests, issues them one at a time and returns results
// Ports: clk_i, rst_ni (async active-low); req_valid_i/req_ready_o with
// req_a_i/req_b_i/req_op_i request channel; alu_a_o/alu_b_o/alu_op_o to the
// ALU and alu_res_i back; rsp_valid_o/rsp_ready_i with rsp_data_o/rsp_err_o
// response channel; busy_o and count_o status.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int SETTLE_CYC = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [31:0]            req_a_i,
  input  logic [31:0]            req_b_i,
  input  logic [4:0]             req_op_i,
  output logic [31:0]            alu_a_o,
  output logic [31:0]            alu_b_o,
  output logic [4:0]             alu_op_o,
  input  logic [31:0]            alu_res_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [31:0]            rsp_data_o,
  output logic                   rsp_err_o,
  output logic                   busy_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int SW = SETTLE_CYC > 1 ? $clog2(SETTLE_CYC) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;
  state_e        state_q;
  logic [SW-1:0] settle_q;
  logic [31:0]   alu_a_q, alu_b_q, rsp_data_q;
  op_t           alu_op_q;
  logic          rsp_valid_q, rsp_err_q;
  alu_req_t      req_in, head;
  logic          full, empty, pop;
  assign req_in = '{a: req_a_i, b: req_b_i, op: req_op_i};
  assign pop    = (state_q == IDLE) & ~empty;
  alu_req_fifo #(.DEPTH(DEPTH), .T(alu_req_t)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (req_valid_i),
    .data_i  (req_in),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count_o)
  );
  assign req_ready_o = ~full;
  assign busy_o      = (state_q != IDLE) | ~empty;
  assign alu_a_o     = alu_a_q;
  assign alu_b_o     = alu_b_q;
  assign alu_op_o    = alu_op_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;
  // Illegal opcodes skip the ALU entirely so its inputs keep the last issued op.
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q     <= IDLE;
      settle_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= op_t'(OP_ADD);
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (!empty) begin
          if (head.op > op_t'(OP_LAST)) begin
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            alu_a_q  <= head.a;
            alu_b_q  <= head.b;
            alu_op_q <= head.op;
            settle_q <= SW'(SETTLE_CYC - 1);
            state_q  <= ISSUE;
          end
        end
        ISSUE: if (settle_q == '0) begin
          rsp_data_q  <= alu_res_i;
          rsp_err_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end else begin
          settle_q <= settle_q - SW'(1);
        end
        RESP: if (rsp_ready_i) begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule
